// File: rtl/rv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the register-file write-port arbiter:
//   - default widths/sizes for data, register index, buffer depth and the
//     age threshold that forces a write-back bubble
//   - the pending-write entry record (valid, reg, data, age)
//   - a saturating increment helper for the entry age counter
// ---------------------------------------------------------------------------
package rv_pipe_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_REG_SIZE  = 5;
    localparam int DEF_DEPTH     = 2;
    localparam int DEF_AGE_LIMIT = 4;

    // Wide enough to represent AGE_LIMIT itself, so "age >= AGE_LIMIT" is
    // reachable before the counter saturates.
    localparam int AGE_W = $clog2(DEF_AGE_LIMIT + 1);

    typedef struct packed {
        logic                     valid;
        logic [DEF_REG_SIZE-1:0]  reg_idx;
        logic [DEF_WORD_SIZE-1:0] data;
        logic [AGE_W-1:0]         age;
    } wb_entry_t;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
        return (&age) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// ---------------------------------------------------------------------------
// wb_pending_fifo
// In-order buffer of MDU results waiting for the register-file write port.
// Entries whose register is overwritten by a pipeline write are invalidated
// in place; invalid entries at the head or tail are squeezed out on the same
// clock edge, so the head slot is always valid whenever count != 0 and no
// port cycle is ever spent on a dead entry.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   push/push_reg/push_data  append a new entry at the tail (age 0)
//   pop                   retire the head entry (head must be valid)
//   inv/inv_reg           invalidate every buffered entry targeting inv_reg
//   head                  oldest entry
//   slots                 raw storage, used by the owner to build masks
//   count                 occupied slots
// ---------------------------------------------------------------------------
module wb_pending_fifo
    import rv_pipe_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DEF_REG_SIZE-1:0]  push_reg,
    input  logic [DEF_WORD_SIZE-1:0] push_data,
    input  logic                     pop,
    input  logic                     inv,
    input  logic [DEF_REG_SIZE-1:0]  inv_reg,
    output wb_entry_t                head,
    output wb_entry_t [DEPTH-1:0]    slots,
    output logic [CNT_W-1:0]         count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t [DEPTH-1:0] mem, mem_n;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CNT_W-1:0]      cnt, cnt_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves one unassigned, which would infer a latch.
        mem_n = mem;
        rd_n  = rd_ptr;
        wr_n  = wr_ptr;
        cnt_n = cnt;

        // Age live entries; an overwritten register kills its entry.
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid) begin
                if (inv && (mem[i].reg_idx == inv_reg)) begin
                    mem_n[i].valid = 1'b0;
                end else begin
                    mem_n[i].age = age_inc(mem[i].age);
                end
            end
        end

        if (pop) begin
            mem_n[rd_ptr].valid = 1'b0;
        end

        // Existing entries only: a result arriving this cycle is not yet
        // buffered, so a same-cycle pipeline write does not kill it.
        if (push) begin
            mem_n[wr_ptr] = '{valid: 1'b1, reg_idx: push_reg, data: push_data, age: '0};
            wr_n          = ptr_inc(wr_ptr);
            cnt_n         = cnt + 1'b1;
        end

        // Squeeze dead slots off both ends so occupancy tracks live entries.
        for (int i = 0; i < DEPTH; i++) begin
            if ((cnt_n != '0) && !mem_n[rd_n].valid) begin
                rd_n  = ptr_inc(rd_n);
                cnt_n = cnt_n - 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((cnt_n != '0) && !mem_n[ptr_dec(wr_n)].valid) begin
                wr_n  = ptr_dec(wr_n);
                cnt_n = cnt_n - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage is reset here because a handful of entries
            // must come up invalid with zero age; large data arrays would
            // normally reset only their valid bits.
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            mem    <= mem_n;
            rd_ptr <= rd_n;
            wr_ptr <= wr_n;
            cnt    <= cnt_n;
        end
    end

    assign head  = mem[rd_ptr];
    assign slots = mem;
    assign count = cnt;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the pipeline write-back
// stage (always wins, never stalled) and a multi-cycle unit whose results are
// parked in a small in-order buffer until the port is free.
//
// Ports
//   clk, reset_n                         clock, asynchronous active-low reset
//   WbRegWrite/WbWriteReg/WbWriteData    pipeline write-back request
//   MduValid/MduReg/MduData, MduReady    MDU result handshake
//   RegWrite/WriteReg/WriteData          registered register-file write port
//   StallReq                             ask hazard unit for a WB bubble
//   PendingMask                          registers with a buffered write
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import rv_pipe_pkg::*;
#(
    parameter int word_size = DEF_WORD_SIZE,
    parameter int reg_size  = DEF_REG_SIZE,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   WbRegWrite,
    input  logic [reg_size-1:0]    WbWriteReg,
    input  logic [word_size-1:0]   WbWriteData,
    input  logic                   MduValid,
    input  logic [reg_size-1:0]    MduReg,
    input  logic [word_size-1:0]   MduData,
    output logic                   MduReady,
    output logic                   RegWrite,
    output logic [reg_size-1:0]    WriteReg,
    output logic [word_size-1:0]   WriteData,
    output logic                   StallReq,
    output logic [2**reg_size-1:0] PendingMask
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] slots;
    logic [CNT_W-1:0]      count;

    logic wb_req;
    logic head_valid;
    logic drain;
    logic push;
    logic full;

    // Register 0 is hard-wired; a write to it is no request at all.
    assign wb_req     = WbRegWrite && (WbWriteReg != '0);
    assign head_valid = (count != '0) && head.valid;
    assign drain      = !wb_req && head_valid;

    // Readiness comes from the registered count only, so an accepted result
    // is never visible at the head in its own cycle (no input-to-port path).
    assign full     = (count == CNT_W'(DEPTH));
    assign MduReady = !full;
    // A result for register 0 completes the handshake but is dropped.
    assign push     = MduValid && MduReady && (MduReg != '0);

    assign StallReq = (head_valid && (head.age >= AGE_W'(AGE_LIMIT))) ||
                      (full && MduValid);

    wb_pending_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_reg  (MduReg),
        .push_data (MduData),
        .pop       (drain),
        .inv       (wb_req),
        .inv_reg   (WbWriteReg),
        .head      (head),
        .slots     (slots),
        .count     (count)
    );

    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slots[i].valid) begin
                PendingMask[slots[i].reg_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= wb_req || drain;
            if (wb_req) begin
                WriteReg  <= WbWriteReg;
                WriteData <= WbWriteData;
            end else if (drain) begin
                WriteReg  <= head.reg_idx;
                WriteData <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios followed by random traffic, every cycle compared with a
// queue-based model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DEPTH     = 2;
    localparam int AGE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_reg = '0;
    logic [31:0] wb_write_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_reg = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        stall_req;
    logic [31:0] pending_mask;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .WbRegWrite  (wb_reg_write),
        .WbWriteReg  (wb_write_reg),
        .WbWriteData (wb_write_data),
        .MduValid    (mdu_valid),
        .MduReg      (mdu_reg),
        .MduData     (mdu_data),
        .MduReady    (mdu_ready),
        .RegWrite    (reg_write),
        .WriteReg    (write_reg),
        .WriteData   (write_data),
        .StallReq    (stall_req),
        .PendingMask (pending_mask)
    );

    always #5 clk = ~clk;

    // Model: live buffered writes, oldest first; dead entries simply vanish.
    typedef struct {
        int unsigned rg;
        logic [31:0] data;
        int unsigned age;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        exp_rw = 1'b0;
    logic [4:0]  exp_wr = '0;
    logic [31:0] exp_wd = '0;
    bit          last_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit wv, input int wr, input logic [31:0] wd,
                          input bit mv, input int mr, input logic [31:0] md);
        wb_reg_write  = wv;
        wb_write_reg  = 5'(wr);
        wb_write_data = wd;
        mdu_valid     = mv;
        mdu_reg       = 5'(mr);
        mdu_data      = md;
    endtask

    // Called just after a falling edge with inputs applied: compare, advance
    // the model by one clock, and return at the next falling edge.
    task automatic step();
        logic [31:0] m_mask;
        bit          m_ready, m_stall, wb_req;
        m_mask = '0;
        foreach (mq[i]) m_mask[mq[i].rg] = 1'b1;
        m_ready = (mq.size() < DEPTH);
        m_stall = (mq.size() > 0 && mq[0].age >= AGE_LIMIT) ||
                  (mq.size() == DEPTH && mdu_valid);
        #1;
        check("mdu_ready",    64'(mdu_ready),    64'(m_ready));
        check("stall_req",    64'(stall_req),    64'(m_stall));
        check("pending_mask", 64'(pending_mask), 64'(m_mask));
        check("reg_write",    64'(reg_write),    64'(exp_rw));
        check("write_reg",    64'(write_reg),    64'(exp_wr));
        check("write_data",   64'(write_data),   64'(exp_wd));
        last_stall = m_stall;

        wb_req = wb_reg_write && (wb_write_reg != 0);
        if (wb_req) begin
            exp_rw = 1'b1;
            exp_wr = wb_write_reg;
            exp_wd = wb_write_data;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].rg == wb_write_reg) mq.delete(i);
        end else if (mq.size() > 0) begin
            exp_rw = 1'b1;
            exp_wr = 5'(mq[0].rg);
            exp_wd = mq[0].data;
            void'(mq.pop_front());
        end else begin
            exp_rw = 1'b0;
        end
        foreach (mq[i]) if (mq[i].age < AGE_LIMIT) mq[i].age++;
        if (mdu_valid && m_ready && mdu_reg != 0)
            mq.push_back('{rg: mdu_reg, data: mdu_data, age: 0});

        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_reg_write",  64'(reg_write),    64'd0);
        check("rst_write_reg",  64'(write_reg),    64'd0);
        check("rst_write_data", 64'(write_data),   64'd0);
        check("rst_mask",       64'(pending_mask), 64'd0);
        check("rst_mdu_ready",  64'(mdu_ready),    64'd1);
        check("rst_stall",      64'(stall_req),    64'd0);
        mq.delete();
        exp_rw = 1'b0;
        exp_wr = '0;
        exp_wd = '0;
        last_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit seen_mdu, seen_stall;
        int drained[$];

        @(negedge clk);
        do_reset();

        // Idle port: result buffered, then written one cycle later.
        set_in(0, 0, 0, 1, 5, 32'h14);
        step();
        check("t30_mask_set", 64'(pending_mask[5]), 64'd1);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        check("t30_rw",       64'(reg_write),       64'd1);
        check("t30_wr",       64'(write_reg),       64'd5);
        check("t30_wd",       64'(write_data),      64'h14);
        check("t30_mask_clr", 64'(pending_mask[5]), 64'd0);
        step();

        // Collision: WB busy on reg 2, MDU entry ages into a forced bubble.
        seen_mdu = 0;
        seen_stall = 0;
        set_in(1, 2, 32'h16, 1, 3, 32'h20);
        step();
        for (int i = 0; i < 10; i++) begin
            set_in(!last_stall, 2, 32'h16, 0, 0, 0);
            step();
            if (last_stall) seen_stall = 1;
            if (reg_write && write_reg == 3 && write_data == 32'h20) seen_mdu = 1;
        end
        check("t31_stall_seen", 64'(seen_stall), 64'd1);
        check("t31_mdu_drain",  64'(seen_mdu),   64'd1);

        // Full buffer under continuous WB traffic; drains in order.
        set_in(1, 1, 32'h11, 1, 4, 32'h40);
        step();
        set_in(1, 1, 32'h11, 1, 6, 32'h60);
        step();
        check("t32_not_ready", 64'(mdu_ready), 64'd0);
        for (int i = 0; i < 14; i++) begin
            set_in(!last_stall, 1, 32'h11, i < 3, 9, 32'h90);
            step();
            if (reg_write && write_reg != 1) drained.push_back(write_reg);
        end
        check("t32_drains", 64'(drained.size()), 64'd3);
        check("t32_first",  64'(drained.size() > 0 ? drained[0] : 99), 64'd4);
        check("t32_second", 64'(drained.size() > 1 ? drained[1] : 99), 64'd6);

        // WAW: pipeline write kills the older buffered result.
        do_reset();
        set_in(0, 0, 0, 1, 7, 32'hAA);
        step();
        set_in(1, 7, 32'hBB, 0, 0, 0);
        step();
        check("t33_wd",       64'(write_data),      64'hBB);
        check("t33_mask_clr", 64'(pending_mask[7]), 64'd0);
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        // Register 0 on both paths: handshake completes, nothing written.
        set_in(1, 0, 32'h55, 1, 0, 32'h66);
        check("t34_ready", 64'(mdu_ready), 64'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        check("t34_mask", 64'(pending_mask), 64'd0);
        step();
        check("t34_rw", 64'(reg_write), 64'd0);

        // Reset with two entries buffered.
        set_in(1, 1, 32'h1, 1, 4, 32'h44);
        step();
        set_in(1, 1, 32'h1, 1, 6, 32'h66);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step();

        // Random traffic with the hazard unit honouring every stall request.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                do_reset();
            end
            set_in(!last_stall && ($urandom_range(0, 9) < 6), $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
